// File: rtl/tt10_uart_rx.sv
// 8N1 UART receiver feeding the tt10 core: synchronises the serial pin, recovers
// bytes, and offers them over a valid/ready handshake with framing/overrun status.
module tt10_uart_rx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clr_err,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'(HALF_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          rx_meta;
    logic          rx_s;
    logic [1:0]    sync_fill;
    logic          armed;

    // The synchroniser resets to idle-high, so sync_fill keeps those reset
    // values from arming the receiver before a real pin sample has arrived.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            sync_fill <= 2'b00;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            armed     <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (sync_fill[1] && rx_s) begin
                armed <= 1'b1;
            end
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (clr_err) begin
                overrun <= 1'b0;
            end

            // Later assignments below deliberately override the accept/clear above.
            case (state)
                S_IDLE: begin
                    if (armed && !rx_s) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (cnt == HALF_CNT) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == LAST_CNT) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == LAST_CNT) begin
                        cnt <= '0;
                        if (rx_s) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            if (rx_valid && !rx_ready) begin
                                overrun <= 1'b1;
                            end
                            state <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            armed     <= 1'b0;
                            state     <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: doc/tt10_uart_rx.md
Name: tt10_uart_rx

Overview:
- 8N1 UART receiver that sits directly upstream of the tt10 core logic.
- Samples the serial pin routed from ui_in[3], recovers bytes and hands them to the core over a valid/ready handshake.
- Reports framing errors (pulse) and overruns (sticky flag) so the core can mirror them on uo_out.

Parameters:
- CLKS_PER_BIT, 87, clk cycles per UART bit (10 MHz / 115200); legal range >= 4.
- HALF_BIT, CLKS_PER_BIT/2 (integer division), cycles from start-edge detect to start-bit mid-sample; derived, not overridable.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous active-high reset; one clock domain only.
- rx  input  1  raw serial line; idle high; asynchronous to clk.
- rx_data  output  8  received byte; valid while rx_valid=1.
- rx_valid  output  1  byte available; held until accepted.
- rx_ready  input  1  consumer accept; transfer occurs on a cycle with rx_valid & rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky: a byte completed while the previous one was still unaccepted.
- clr_err  input  1  clears overrun on the next edge.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchronizer flops = 1; state = IDLE; armed = 0.
- Synchronizer:
  - Two flops on rx; rx_s is the second flop.
  - Latency is 2 clk from pin to rx_s.
- Armed bit:
  - Set on the first cycle rx_s=1 after reset or after a break.
  - Start detection is only allowed when armed=1, so a line held low through reset never produces a byte.
- Counter:
  - bit_cnt is ceil(log2(CLKS_PER_BIT)) bits wide.
  - Reset to 0 on every state entry; increments by 1 each cycle in non-IDLE states.
- State IDLE:
  - Exit: armed & rx_s==0 -> START, cnt=0.
- State START:
  - Action: when cnt==HALF_BIT, sample rx_s.
  - Exit: rx_s=0 -> DATA (cnt=0, bit_idx=0); rx_s=1 -> IDLE (glitch rejected, no outputs change).
- State DATA:
  - Action: when cnt==CLKS_PER_BIT-1, shift rx_s into shift[7] (right shift, LSB first) and restart cnt.
  - Exit: after bit_idx 7 is sampled -> STOP.
- State STOP:
  - Action: when cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1 (good stop), next cycle:
    - rx_data<=shift, rx_valid<=1.
    - If rx_valid was already 1 and rx_ready=0 that cycle, set overrun; the old byte is overwritten.
    - State -> IDLE.
  - rx_s=0 (bad stop):
    - frame_err pulses for 1 cycle; rx_data and rx_valid are unchanged.
    - State -> BREAK.
- State BREAK:
  - Exit: wait for rx_s=1 -> IDLE; this prevents a held-low line retriggering.
- Handshake:
  - rx_valid clears on the edge after rx_valid & rx_ready.
  - rx_data is stable while rx_valid=1, except when overwritten on overrun.
- Simultaneous events:
  - Accept and new-byte load in the same cycle: the new byte loads, rx_valid stays 1, no overrun.
  - clr_err and an overrun event in the same cycle: overrun ends up set (set wins).
- Reset mid-frame: async return to reset values immediately; the partial byte is discarded.
- Frame timing: a byte reaches rx_valid about 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 clk after the start edge at the pin.
- Back-to-back frames: a start edge right after the stop bit is accepted.

Test Plan (CLKS_PER_BIT=8):
- Byte 0xA5 sent at 8 clk/bit, rx_ready=0 -> rx_valid=1, rx_data=0xA5; it stays held; rx_ready pulse -> rx_valid=0 next cycle.
- 3-cycle low glitch on idle line -> no rx_valid, busy returns to 0 within HALF_BIT+3 cycles, state IDLE.
- Frame 0x3C with stop bit low, then line held low 40 cycles -> frame_err one-cycle pulse, rx_valid=0; following good 0x81 after the line goes high -> rx_data=0x81.
- Bytes 0x11 then 0x22 back-to-back, rx_ready=0 -> rx_data=0x22, overrun=1; clr_err pulse -> overrun=0.
- 0x11 pending, rx_ready asserted exactly on 0x22's load cycle -> rx_data=0x22, rx_valid=1, overrun=0.
- rst asserted during bit 4 of 0xFF, rx low through reset release -> all outputs 0, no byte until the line goes high and a fresh 0x5A frame arrives -> rx_data=0x5A.
